// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-write store buffer and the data memory.
package store_buffer_pkg;
  localparam int DATA_W        = 32;
  localparam int SB_DEPTH      = 4;
  localparam int WORD_ADDR_LSB = 2;
  localparam int WADDR_W       = DATA_W - WORD_ADDR_LSB;

  typedef struct packed {
    logic               valid;
    logic [WADDR_W-1:0] addr;
    logic [DATA_W-1:0]  data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_forward_match.sv
// Youngest-first search of the buffered stores for a word address; used for load forwarding.
module sb_forward_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH    = SB_DEPTH,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0]    entries,
  input  logic [PTR_BITS-1:0]      tail,
  input  logic [WADDR_W-1:0]       addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  logic [PTR_BITS-1:0] idx;

  // Walk oldest to youngest (tail-DEPTH .. tail-1) so the youngest match overwrites older ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PTR_BITS'(k);
      if (entries[idx].valid && (entries[idx].addr == addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: queues stores, drains them in order on free memory-port cycles,
// and forwards the youngest pending store data to matching loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH    = SB_DEPTH,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wdata,
  input  logic                cpu_memread,
  input  logic                cpu_memwrite,
  output logic [31:0]         cpu_rdata,
  output logic                cpu_stall,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                mem_memread,
  output logic                mem_memwrite,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_wready,
  output logic                empty,
  output logic [PTR_BITS:0]   count
);

  localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS + 1)'(DEPTH);

  logic [PTR_BITS-1:0] head;
  logic [PTR_BITS-1:0] tail;
  logic [DEPTH-1:0]    valid_q;
  logic [WADDR_W-1:0]  addr_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  sb_entry_t [DEPTH-1:0] entries;

  logic              pop;
  logic              push;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign empty     = (count == '0);
  assign pop       = mem_memwrite & mem_wready;
  assign cpu_stall = cpu_memwrite & (count == FULL_CNT) & ~pop;
  assign push      = cpu_memwrite & ~cpu_stall;

  // Loads own the port; otherwise the head store is offered to memory.
  always_comb begin
    mem_memread  = cpu_memread;
    mem_memwrite = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (cpu_memread) begin
      mem_addr = cpu_addr;
    end else if (!empty) begin
      mem_memwrite = 1'b1;
      mem_addr     = {addr_q[head], {WORD_ADDR_LSB{1'b0}}};
      mem_wdata    = data_q[head];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i].valid = valid_q[i];
      entries[i].addr  = addr_q[i];
      entries[i].data  = data_q[i];
    end
  end

  sb_forward_match #(
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_match (
    .entries (entries),
    .tail    (tail),
    .addr    (cpu_addr[31:WORD_ADDR_LSB]),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  assign cpu_rdata = !cpu_memread ? '0 : (fwd_hit ? fwd_data : mem_rdata);

  // Push after pop so a full-buffer pop+push on the same slot leaves it valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      head    <= '0;
      tail    <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        head          <= head + 1'b1;
        valid_q[head] <= 1'b0;
      end
      if (push) begin
        tail          <= tail + 1'b1;
        valid_q[tail] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= cpu_addr[31:WORD_ADDR_LSB];
      data_q[tail] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle plus directed literal checks.
module tb_store_buffer;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
  logic        cpu_memread = 1'b0, cpu_memwrite = 1'b0, mem_wready = 1'b0;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, mem_memread, mem_memwrite, empty;
  logic [2:0]  count;

  typedef struct { logic [29:0] a; logic [31:0] d; } st_t;
  st_t         mq[$];
  logic [63:0] wlog[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  store_buffer dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_rdata(mem_rdata),
    .mem_wready(mem_wready), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy, input logic [31:0] mrd);
    cpu_memread = rd; cpu_memwrite = wr; cpu_addr = a; cpu_wdata = wd;
    mem_wready = rdy; mem_rdata = mrd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    for (int i = 0; i < 40 && empty !== 1'b1; i++) tick();
    chk("drain_done", 32'(empty), 32'd1);
  endtask

  // Reference model: FIFO of pending stores, updated at each edge from the spec rules.
  always @(posedge clk or posedge reset) begin
    int   n;
    logic m_pop, m_push;
    if (reset) begin
      mq.delete();
    end else begin
      n      = mq.size();
      m_pop  = !cpu_memread && n > 0 && mem_wready;
      m_push = cpu_memwrite && !(n == D && !m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{cpu_addr[31:2], cpu_wdata});
    end
  end

  // Per-cycle comparison and memory write log, sampled mid-cycle.
  always @(negedge clk) begin
    int          n;
    logic        e_mw, e_pop, e_stall;
    logic [31:0] e_addr, e_wdata, e_rdata;
    n       = mq.size();
    e_mw    = !cpu_memread && n > 0;
    e_pop   = e_mw && mem_wready;
    e_stall = cpu_memwrite && n == D && !e_pop;
    e_addr  = cpu_memread ? cpu_addr : (n > 0 ? {mq[0].a, 2'b00} : 32'h0);
    e_wdata = e_mw ? mq[0].d : 32'h0;
    e_rdata = 32'h0;
    if (cpu_memread) begin
      e_rdata = mem_rdata;
      for (int i = 0; i < n; i++)
        if (mq[i].a == cpu_addr[31:2]) e_rdata = mq[i].d;
    end
    chk("m_count", 32'(count), 32'(n));
    chk("m_empty", 32'(empty), 32'(n == 0));
    chk("m_stall", 32'(cpu_stall), 32'(e_stall));
    chk("m_memwrite", 32'(mem_memwrite), 32'(e_mw));
    chk("m_memread", 32'(mem_memread), 32'(cpu_memread));
    chk("m_mem_addr", mem_addr, e_addr);
    chk("m_mem_wdata", mem_wdata, e_wdata);
    chk("m_cpu_rdata", cpu_rdata, e_rdata);
    if (!reset && mem_memwrite && mem_wready) wlog.push_back({mem_addr, mem_wdata});
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int tries;
    // Reset state
    drive(1'b1, 1'b1, 32'h40, 32'h1, 1'b1, 32'h77);
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_memwrite", 32'(mem_memwrite), 32'd0);
    chk("rst_memread", 32'(mem_memread), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Basic drain
    base = wlog.size();
    drive(1'b0, 1'b1, 32'h10, 32'hAAAA0001, 1'b1, 32'h0);
    #1 chk("bd_no_stall", 32'(cpu_stall), 32'd0);
    chk("bd_no_bypass", 32'(mem_memwrite), 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    #1 chk("bd_count1", 32'(count), 32'd1);
    chk("bd_memwrite", 32'(mem_memwrite), 32'd1);
    chk("bd_addr", mem_addr, 32'h10);
    chk("bd_wdata", mem_wdata, 32'hAAAA0001);
    tick();
    chk("bd_empty", 32'(empty), 32'd1);
    chk("bd_log_n", 32'(wlog.size() - base), 32'd1);

    // Forwarding
    drive(1'b0, 1'b1, 32'h20, 32'd1, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b1, 32'h20, 32'd2, 1'b0, 32'h0); tick();
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678);
    #1 chk("fw_hit", cpu_rdata, 32'd2);
    chk("fw_no_write", 32'(mem_memwrite), 32'd0);
    drive(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'hCAFEF00D);
    #1 chk("fw_miss", cpu_rdata, 32'hCAFEF00D);
    base = wlog.size();
    drain_all();
    chk("fw_log0", wlog[base][31:0], 32'd1);
    chk("fw_log1", wlog[base+1][31:0], 32'd2);

    // Full / stall
    base = wlog.size();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 32'(32'h100 + 4 * i), 32'(i + 1), 1'b0, 32'h0);
      tick();
    end
    chk("fs_count4", 32'(count), 32'd4);
    drive(1'b0, 1'b1, 32'h110, 32'd5, 1'b0, 32'h0);
    #1 chk("fs_stall", 32'(cpu_stall), 32'd1);
    tick();
    chk("fs_no_push", 32'(count), 32'd4);
    drive(1'b0, 1'b1, 32'h110, 32'd5, 1'b1, 32'h0);
    #1 chk("fs_stall_drop", 32'(cpu_stall), 32'd0);
    tick();
    chk("fs_count_hold", 32'(count), 32'd4);
    drain_all();
    for (int k = 0; k < 5; k++) begin
      chk("fs_order_data", wlog[base+k][31:0], 32'(k + 1));
      chk("fs_order_addr", wlog[base+k][63:32], 32'(32'h100 + 4 * k));
    end

    // Load priority
    drive(1'b0, 1'b1, 32'h200, 32'hA, 1'b0, 32'h0); tick();
    drive(1'b0, 1'b1, 32'h204, 32'hB, 1'b0, 32'h0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'h55AA0000 + 32'(i));
      #1 chk("lp_no_write", 32'(mem_memwrite), 32'd0);
      chk("lp_count", 32'(count), 32'd2);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    #1 chk("lp_resume", 32'(mem_memwrite), 32'd1);
    chk("lp_resume_addr", mem_addr, 32'h200);
    drain_all();

    // Wrap-around with random write-ready
    base = wlog.size();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 32'(32'h400 + 4 * i), 32'(32'h1000 + i), 1'($urandom_range(0, 1)), 32'h0);
      #1;
      tries = 0;
      while (cpu_stall && tries < 16) begin
        tick();
        mem_wready = (tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        tries++;
      end
      chk("wr_cnt_le4", 32'(count <= 3'd4), 32'd1);
      tick();
    end
    drain_all();
    chk("wr_log_n", 32'(wlog.size() - base), 32'd10);
    for (int k = 0; k < 10 && base + k < wlog.size(); k++) begin
      chk("wr_order_addr", wlog[base+k][63:32], 32'(32'h400 + 4 * k));
      chk("wr_order_data", wlog[base+k][31:0], 32'(32'h1000 + k));
    end

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'(32'h800 + 4 * i), 32'(i + 7), 1'b0, 32'h0);
      tick();
    end
    chk("rm_count3", 32'(count), 32'd3);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2 reset = 1'b1;
    #1 chk("rm_count0", 32'(count), 32'd0);
    chk("rm_empty", 32'(empty), 32'd1);
    chk("rm_memwrite", 32'(mem_memwrite), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    base = wlog.size();
    tick(); tick(); tick();
    chk("rm_no_writes", 32'(wlog.size() - base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
